// File: rtl/dff_sel_pipe.sv
// dff_sel_pipe: lane-selecting valid/ready register pipeline with bubble collapse and synchronous flush
module dff_sel_pipe #(
  parameter int N = 5,
  parameter int M = 2,
  parameter int DEPTH = 2,
  parameter logic [N-1:0] VAL = N'(31)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [M*N-1:0]               data_i,
  input  logic [$clog2(M)-1:0]         sel_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic                         flush_i,
  output logic [N-1:0]                 y_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int CW = $clog2(DEPTH+1);
  logic [N-1:0] d [DEPTH];
  logic [DEPTH-1:0] v, move;
  logic [N-1:0] word;
  logic accept;
  always_comb begin
    word = VAL;
    for (int k = 0; k < M; k++) word = (int'(sel_i) == k) ? data_i[k*N +: N] : word;
  end
  // a stage moves when its successor is empty or moving itself, so bubbles collapse
  always_comb begin
    move = '0;
    move[DEPTH-1] = v[DEPTH-1] & ready_i;
    for (int s = DEPTH-2; s >= 0; s--) move[s] = v[s] & (~v[s+1] | move[s+1]);
  end
  assign ready_o = ~flush_i & (~v[0] | move[0]);
  assign accept = valid_i & ready_o;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      v <= '0;
      for (int s = 0; s < DEPTH; s++) d[s] <= VAL;
    end else if (flush_i) begin
      v <= '0;
      for (int s = 0; s < DEPTH; s++) d[s] <= VAL;
    end else begin
      if (accept) begin
        d[0] <= word;
        v[0] <= 1'b1;
      end else if (move[0]) v[0] <= 1'b0;
      for (int s = 1; s < DEPTH; s++)
        if (move[s-1]) begin
          d[s] <= d[s-1];
          v[s] <= 1'b1;
        end else if (move[s]) v[s] <= 1'b0;
    end
  end
  always_comb begin
    count_o = '0;
    for (int s = 0; s < DEPTH; s++) count_o = count_o + CW'(v[s]);
  end
  assign y_o = d[DEPTH-1];
  assign valid_o = v[DEPTH-1];
endmodule

// File: tb/tb_dff_sel_pipe.sv
// tb_dff_sel_pipe: directed table, hand sequences and randomized model comparison for dff_sel_pipe
module tb_dff_sel_pipe;
  localparam int N = 5, M = 2, D = 2;
  localparam logic [N-1:0] VAL = 5'd31;
  logic clk = 1'b0, rst_n = 1'b0;
  logic valid = 1'b0, sel = 1'b0, flush = 1'b0, rdy = 1'b0;
  logic [M*N-1:0] data = '0;
  logic ready_o, valid_o;
  logic [N-1:0] y;
  logic [1:0] count;
  logic valid1 = 1'b0;
  logic [1:0] sel1 = 2'd0;
  logic [3*N-1:0] data1 = '0;
  logic ready_o1, valid_o1;
  logic [N-1:0] y1;
  logic [1:0] count1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  dff_sel_pipe #(.N(N), .M(M), .DEPTH(D), .VAL(VAL)) u0 (
    .clk_i(clk), .rst_i(rst_n), .data_i(data), .sel_i(sel), .valid_i(valid),
    .ready_o(ready_o), .flush_i(flush), .y_o(y), .valid_o(valid_o),
    .ready_i(rdy), .count_o(count));
  dff_sel_pipe #(.N(N), .M(3), .DEPTH(D), .VAL(VAL)) u1 (
    .clk_i(clk), .rst_i(rst_n), .data_i(data1), .sel_i(sel1), .valid_i(valid1),
    .ready_o(ready_o1), .flush_i(1'b0), .y_o(y1), .valid_o(valid_o1),
    .ready_i(1'b1), .count_o(count1));
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  typedef struct {
    logic vi, s, fl, ri, e_rdy, e_v;
    logic [N-1:0] l0, l1, e_y;
    logic [1:0] e_c;
  } row_t;
  function automatic row_t r(int vi, int s, int l0, int l1, int fl, int ri, int er, int ev, int ey, int ec);
    row_t x;
    x.vi = 1'(vi); x.s = 1'(s); x.l0 = 5'(l0); x.l1 = 5'(l1); x.fl = 1'(fl); x.ri = 1'(ri);
    x.e_rdy = 1'(er); x.e_v = 1'(ev); x.e_y = 5'(ey); x.e_c = 2'(ec);
    return x;
  endfunction
  // behavioural model: slots fill from the output end; a slot advances when the next one is free
  logic [N-1:0] my [D];
  bit mv [D];
  task automatic model_reset();
    for (int s = 0; s < D; s++) begin
      my[s] = VAL;
      mv[s] = 1'b0;
    end
  endtask
  function automatic bit model_ready();
    bit t [D];
    if (flush) return 1'b0;
    t = mv;
    if (t[D-1] && rdy) t[D-1] = 1'b0;
    for (int s = D-2; s >= 0; s--)
      if (t[s] && !t[s+1]) begin
        t[s+1] = 1'b1;
        t[s] = 1'b0;
      end
    return !t[0];
  endfunction
  task automatic model_edge();
    if (flush) begin
      model_reset();
      return;
    end
    if (mv[D-1] && rdy) mv[D-1] = 1'b0;
    for (int s = D-2; s >= 0; s--)
      if (mv[s] && !mv[s+1]) begin
        my[s+1] = my[s];
        mv[s+1] = 1'b1;
        mv[s] = 1'b0;
      end
    if (valid && !mv[0]) begin
      my[0] = data[int'(sel)*N +: N];
      mv[0] = 1'b1;
    end
  endtask
  function automatic int model_count();
    int c = 0;
    for (int s = 0; s < D; s++) c += int'(mv[s]);
    return c;
  endfunction
  row_t tbl [13];
  initial begin
    tbl[0]  = r(1, 1, 0, 7, 0, 1, 1, 0, 31, 1);
    tbl[1]  = r(0, 0, 0, 0, 0, 1, 1, 1, 7, 1);
    tbl[2]  = r(0, 0, 0, 0, 0, 1, 1, 0, 7, 0);
    tbl[3]  = r(1, 0, 3, 0, 0, 0, 1, 0, 7, 1);
    tbl[4]  = r(1, 0, 4, 0, 0, 0, 1, 1, 3, 2);
    tbl[5]  = r(1, 0, 5, 0, 0, 0, 0, 1, 3, 2);
    tbl[6]  = r(1, 0, 5, 0, 0, 1, 1, 1, 4, 2);
    tbl[7]  = r(0, 0, 0, 0, 0, 1, 1, 1, 5, 1);
    tbl[8]  = r(0, 0, 0, 0, 0, 1, 1, 0, 5, 0);
    tbl[9]  = r(1, 0, 9, 0, 0, 0, 1, 0, 5, 1);
    tbl[10] = r(1, 0, 10, 0, 0, 0, 1, 1, 9, 2);
    tbl[11] = r(1, 0, 12, 0, 1, 0, 0, 0, 31, 0);
    tbl[12] = r(0, 0, 0, 0, 0, 1, 1, 0, 31, 0);
    #12;
    chk("reset_y", int'(y), 31);
    chk("reset_valid", int'(valid_o), 0);
    chk("reset_count", int'(count), 0);
    chk("reset_ready", int'(ready_o), 1);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      valid = tbl[i].vi; sel = tbl[i].s; data = {tbl[i].l1, tbl[i].l0};
      flush = tbl[i].fl; rdy = tbl[i].ri;
      #1 chk($sformatf("tbl%0d_ready", i), int'(ready_o), int'(tbl[i].e_rdy));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), int'(valid_o), int'(tbl[i].e_v));
      chk($sformatf("tbl%0d_y", i), int'(y), int'(tbl[i].e_y));
      chk($sformatf("tbl%0d_count", i), int'(count), int'(tbl[i].e_c));
    end
    valid = 1'b0; flush = 1'b0;
    // three-lane instance: lane 2 word, then an out-of-range select yields VAL
    valid1 = 1'b1; sel1 = 2'd2; data1 = {5'd6, 5'd1, 5'd2};
    #1 chk("m3_ready", int'(ready_o1), 1);
    @(posedge clk); @(negedge clk);
    sel1 = 2'd3;
    @(posedge clk); @(negedge clk);
    chk("m3_lane2_valid", int'(valid_o1), 1);
    chk("m3_lane2_y", int'(y1), 6);
    valid1 = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("m3_oob_valid", int'(valid_o1), 1);
    chk("m3_oob_y", int'(y1), 31);
    @(posedge clk); @(negedge clk);
    chk("m3_drain_valid", int'(valid_o1), 0);
    chk("m3_drain_count", int'(count1), 0);
    valid = 1'b1; sel = 1'b0; rdy = 1'b0; data = {5'd0, 5'd17};
    @(posedge clk); @(negedge clk);
    data = {5'd0, 5'd18};
    @(posedge clk); @(negedge clk);
    chk("prerst_count", int'(count), 2);
    chk("prerst_ready", int'(ready_o), 0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_y", int'(y), 31);
    chk("arst_valid", int'(valid_o), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_ready", int'(ready_o), 1);
    valid = 1'b0; rdy = 1'b1;
    #7 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postrst_valid", int'(valid_o), 0);
      chk("postrst_count", int'(count), 0);
    end
    model_reset();
    for (int i = 0; i < 400; i++) begin
      valid = $urandom_range(0, 9) < 7;
      sel = 1'($urandom);
      data = M*N'($urandom);
      flush = $urandom_range(0, 19) == 0;
      rdy = $urandom_range(0, 9) < 6;
      #1 chk("rand_ready", int'(ready_o), int'(model_ready()));
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("rand_valid", int'(valid_o), int'(mv[D-1]));
      chk("rand_y", int'(y), int'(my[D-1]));
      chk("rand_count", int'(count), model_count());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dff_sel_pipe.md
DFF_SEL_PIPE -- requirements
Module: dff_sel_pipe

Interface
REQ-001 SHALL have parameter N, default 5: data width in bits, legal range 1..32.
REQ-002 SHALL have parameter M, default 2: number of selectable data inputs, legal range 2..8.
REQ-003 SHALL have parameter DEPTH, default 2: number of pipeline stages, legal range 1..8.
REQ-004 SHALL have parameter [N-1:0] VAL, default 31: reset and flush value of every stage data register.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port data_i, input, M*N bits: lane k occupies bits [k*N+N-1 : k*N].
REQ-008 SHALL have port sel_i, input, $clog2(M) bits: lane select.
REQ-009 SHALL have port valid_i, input, 1 bit: the selected lane carries a word.
REQ-010 SHALL have port ready_o, output, 1 bit: stage 0 can accept this cycle.
REQ-011 SHALL have port flush_i, input, 1 bit: synchronous pipeline clear.
REQ-012 SHALL have port y_o, output, N bits: data register of stage DEPTH-1.
REQ-013 SHALL have port valid_o, output, 1 bit: y_o holds a valid word.
REQ-014 SHALL have port ready_i, input, 1 bit: the consumer accepts y_o.
REQ-015 SHALL have port count_o, output, $clog2(DEPTH+1) bits: number of valid stages.

Function
REQ-016 SHALL contain DEPTH stages, each with an N-bit data register d[s] and a valid bit v[s].
REQ-017 SHALL compute the selected word as lane sel_i of data_i, or as VAL when sel_i >= M.
REQ-018 SHALL define move[DEPTH-1] = v[DEPTH-1] & ready_i.
REQ-019 SHALL define, for s < DEPTH-1, move[s] = v[s] & (~v[s+1] | move[s+1]), so bubbles collapse.
REQ-020 SHALL drive ready_o = ~flush_i & (~v[0] | move[0]) combinationally.
REQ-021 SHALL accept a word when valid_i & ready_o: d[0] <= selected word and v[0] <= 1.
REQ-022 SHALL, when v[0] is moving out with no new word accepted, clear v[0] and hold d[0].
REQ-023 SHALL, for s > 0 when move[s-1], load d[s] <= d[s-1] and v[s] <= 1.
REQ-024 SHALL, for s > 0 when move[s] & ~move[s-1], clear v[s] and hold d[s].
REQ-025 SHALL hold d[s] and v[s] in every other case; a stalled valid word never changes.
REQ-026 SHALL give a latency of DEPTH cycles from acceptance to valid_o when ready_i is held high, and a throughput of 1 word per cycle.
REQ-027 SHALL drive y_o = d[DEPTH-1] and valid_o = v[DEPTH-1]; y_o holds its last value while valid_o is 0.
REQ-028 SHALL make count_o the population count of v[] as registered, ranging 0..DEPTH.
REQ-029 SHALL, on flush_i = 1 at a clock edge, clear all v[s] and set all d[s] to VAL; flush overrides accept and move in that cycle, and a word offered that cycle is dropped.
REQ-030 SHALL, when full (count_o = DEPTH) and ready_i = 0, drive ready_o = 0; with ready_i = 1 it SHALL drive ready_o = 1 and sustain full throughput.
REQ-031 SHALL, when DEPTH = 1, behave as one muxed register with valid/ready, ready_o = ~flush_i & (~v[0] | ready_i).

Reset
REQ-032 SHALL, while rst_i = 0, asynchronously force all d[s] to VAL, all v[s] to 0, y_o = VAL, valid_o = 0 and count_o = 0, with ready_o = ~flush_i.
REQ-033 SHALL resume accepting on the first rising clk_i edge after rst_i rises.
REQ-034 SHALL discard in-flight words when reset is asserted mid-operation; no partial word appears after release.

Verification
REQ-035 SHALL be verified with: after reset, N=5, M=2, DEPTH=2 -> y_o=31, valid_o=0, count_o=0, ready_o=1.
REQ-036 SHALL be verified with: ready_i=1, valid_i=1, sel_i=1, lane1=7 for one cycle -> valid_o=1 with y_o=7 exactly 2 cycles later, then valid_o=0 with y_o held at 7.
REQ-037 SHALL be verified with: ready_i=0, words 3,4,5 offered -> 3 and 4 accepted, count_o=2, ready_o=0; then ready_i=1 -> 3, 4, 5 emitted in order with none lost or duplicated.
REQ-038 SHALL be verified with: M=3, sel_i=3, valid_i=1 -> VAL (31) is emitted.
REQ-039 SHALL be verified with: pipeline full, flush_i=1 with valid_i=1 -> next cycle count_o=0, valid_o=0, y_o=31, and the offered word is absent.
REQ-040 SHALL be verified with: rst_i pulsed low mid-stream, asynchronous to clk_i -> outputs take their reset values immediately, and no stale word appears after release.
